pred_table_ctrl: RTL

Controller for the 128-entry, 2-bit saturating-counter branch prediction table. It owns the table's single address/data port and shares it between front-end prediction lookups and back-end outcome updates. It also sequences a full-table initialization sweep after reset. The table writes `din` to `memory[line]` on every clock and has no write enable, so this block must drive a value for every cycle.

---
 rtl/pred_pkg.sv | 46 ++++
 rtl/pred_table_ctrl_if.sv | 38 +++
 rtl/pred_upd_fifo.sv | 57 +++++
 rtl/pred_table_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/pred_pkg.sv
// -----------------------------------------------------------------------------
// pred_pkg
// Shared definitions for the branch prediction table controller.
//   LINE_W        : table index width (depth = 2**LINE_W)
//   CNT_*         : 2-bit saturating counter encoding
//   upd_t         : queued outcome update {line, taken}
//   state_t       : controller FSM states
//   grant_t       : per-cycle table port owner in RUN
//   sat_next()    : saturating counter step, never wraps
// -----------------------------------------------------------------------------
package pred_pkg;

   localparam int LINE_W = 7;

   localparam logic [1:0] CNT_SNT = 2'd0;  // strong not-taken
   localparam logic [1:0] CNT_WNT = 2'd1;  // weak not-taken
   localparam logic [1:0] CNT_WT  = 2'd2;  // weak taken
   localparam logic [1:0] CNT_ST  = 2'd3;  // strong taken

   typedef struct packed {
      logic [LINE_W-1:0] line;
      logic              taken;
   } upd_t;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_LOOKUP,
      GNT_UPDATE
   } grant_t;

   // Explicit per-state table so the ends of the range hold instead of wrapping.
   function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
      case (cnt)
         CNT_SNT: return taken ? CNT_WNT : CNT_SNT;
         CNT_WNT: return taken ? CNT_WT  : CNT_SNT;
         CNT_WT:  return taken ? CNT_ST  : CNT_WNT;
         default: return taken ? CNT_ST  : CNT_WT;
      endcase
   endfunction

endpackage

// File: rtl/pred_table_ctrl_if.sv
// -----------------------------------------------------------------------------
// pred_table_ctrl_if
// Request/response bundle between the pipeline and the prediction table
// controller.
//   lookup_valid/lookup_line   -> prediction request
//   lookup_ready/pred_cnt/pred_taken <- grant and counter read in grant cycle
//   upd_valid/upd_line/upd_taken -> resolved-branch update
//   upd_ready                  <- update accepted into the queue
//   init_busy                  <- table init sweep in progress
// master: pipeline side, slave: controller side.
// -----------------------------------------------------------------------------
interface pred_table_ctrl_if #(
   parameter int LINE_W = pred_pkg::LINE_W
);
   import pred_pkg::*;

   logic              lookup_valid;
   logic [LINE_W-1:0] lookup_line;
   logic              lookup_ready;
   logic [1:0]        pred_cnt;
   logic              pred_taken;
   logic              upd_valid;
   logic [LINE_W-1:0] upd_line;
   logic              upd_taken;
   logic              upd_ready;
   logic              init_busy;

   modport master (
      output lookup_valid, lookup_line, upd_valid, upd_line, upd_taken,
      input  lookup_ready, pred_cnt, pred_taken, upd_ready, init_busy
   );

   modport slave (
      input  lookup_valid, lookup_line, upd_valid, upd_line, upd_taken,
      output lookup_ready, pred_cnt, pred_taken, upd_ready, init_busy
   );

endinterface

// File: rtl/pred_upd_fifo.sv
// -----------------------------------------------------------------------------
// pred_upd_fifo
// Two-entry FIFO holding outcome updates until the table port is free.
//   clk, reset (async, active-high)
//   push, push_data  : enqueue (taken when not full, or when popping this cycle)
//   pop              : dequeue head (ignored when empty)
//   head             : oldest entry, valid when !empty
//   full, empty      : occupancy flags
// -----------------------------------------------------------------------------
module pred_upd_fifo
   import pred_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  upd_t push_data,
   input  logic pop,
   output upd_t head,
   output logic full,
   output logic empty
);

   logic [1:0] count;
   logic       wr_ptr;
   logic       rd_ptr;
   logic       push_ok;
   logic       pop_ok;
   upd_t       mem [2];

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign pop_ok  = pop && !empty;
   // When full, a simultaneous pop frees the head slot, which is the write slot.
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(push_ok) - 2'(pop_ok);
      end
   end

   // NOTE: storage is not reset; count alone decides which slots are valid,
   // so a reset flush only needs the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pred_table_ctrl.sv
// -----------------------------------------------------------------------------
// pred_table_ctrl
// Owns the single port of the 2-bit saturating-counter prediction table.
// After reset it sweeps INIT_VAL into every line, then arbitrates the port
// each cycle between prediction lookups and queued outcome updates.
//   clk, reset (async, active-high)
//   bus      : pred_table_ctrl_if.slave (lookup / update handshakes, init_busy)
//   tbl_line : table address
//   tbl_din  : table write data, written unconditionally every clk
//   tbl_dout : table combinational read data at tbl_line
// -----------------------------------------------------------------------------
module pred_table_ctrl #(
   parameter int         LINE_W   = pred_pkg::LINE_W,
   parameter logic [1:0] INIT_VAL = pred_pkg::CNT_WNT
) (
   input  logic              clk,
   input  logic              reset,
   pred_table_ctrl_if.slave  bus,
   output logic [LINE_W-1:0] tbl_line,
   output logic [1:0]        tbl_din,
   input  logic [1:0]        tbl_dout
);
   import pred_pkg::*;

   localparam logic [LINE_W-1:0] LAST_IDX = '1;

   state_t            state, state_nxt;
   logic [LINE_W-1:0] idx, idx_nxt;
   grant_t            grant;
   upd_t              push_data;
   upd_t              head;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;

   assign push      = bus.upd_valid && bus.upd_ready;
   assign push_data = '{line: bus.upd_line, taken: bus.upd_taken};

   // Lookup is zero-latency: the read for the granted line is on tbl_dout now.
   assign bus.pred_cnt   = tbl_dout;
   assign bus.pred_taken = tbl_dout[1];

   pred_upd_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_INIT;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch
      // of the case can leave one unassigned and infer a latch.
      state_nxt        = state;
      idx_nxt          = idx;
      grant            = GNT_IDLE;
      pop              = 1'b0;
      bus.init_busy    = 1'b0;
      bus.lookup_ready = 1'b0;
      bus.upd_ready    = 1'b0;
      // The table writes every cycle, so the idle choice is a no-change write-back.
      tbl_line         = bus.lookup_line;
      tbl_din          = tbl_dout;

      case (state)
         ST_INIT: begin
            bus.init_busy = 1'b1;
            tbl_line      = idx;
            tbl_din       = INIT_VAL;
            idx_nxt       = idx + LINE_W'(1);
            if (idx == LAST_IDX) state_nxt = ST_RUN;
         end

         ST_RUN: begin
            // A pop does not free a slot for this cycle's push; ready looks at full only.
            bus.upd_ready = !full;
            // A full queue outranks lookups so updates cannot be starved forever.
            if (full)                  grant = GNT_UPDATE;
            else if (bus.lookup_valid) grant = GNT_LOOKUP;
            else if (!empty)           grant = GNT_UPDATE;

            case (grant)
               GNT_LOOKUP: bus.lookup_ready = 1'b1;
               GNT_UPDATE: begin
                  tbl_line = head.line;
                  tbl_din  = sat_next(tbl_dout, head.taken);
                  pop      = 1'b1;
               end
               default: ;
            endcase
         end

         default: state_nxt = ST_INIT;
      endcase
   end

endmodule
